// File: rtl/alarm_ctrl_pkg.sv
// rtl/alarm_ctrl_pkg.sv - shared FSM encodings and time-field widths for the alarm stage
package alarm_ctrl_pkg;

    localparam int HOUR_W    = 5;
    localparam int MIN_W     = 6;
    localparam int SEC_W     = 6;
    localparam int SEC_CNT_W = 9;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RING   = 2'd1;
    localparam logic [1:0] ST_SNOOZE = 2'd2;

    typedef struct packed {
        logic [HOUR_W-1:0] h;
        logic [MIN_W-1:0]  m;
        logic [SEC_W-1:0]  s;
    } hms_t;

    function automatic logic hms_equal(input hms_t a, input hms_t b);
        return (a.h == b.h) && (a.m == b.m) && (a.s == b.s);
    endfunction

endpackage

// File: rtl/alarm_ctrl_if.sv
// rtl/alarm_ctrl_if.sv - time, button and ring-status signals between alarm stage and its neighbours
interface alarm_ctrl_if;
    import alarm_ctrl_pkg::*;

    logic              tick_1hz;
    logic              alarm_en;
    logic [HOUR_W-1:0] cur_h;
    logic [MIN_W-1:0]  cur_m;
    logic [SEC_W-1:0]  cur_s;
    logic [HOUR_W-1:0] alm_h;
    logic [MIN_W-1:0]  alm_m;
    logic [SEC_W-1:0]  alm_s;
    logic              stop;
    logic              snooze;
    logic              ringing;
    logic              snoozing;
    logic              beep;
    logic [1:0]        snooze_cnt;

    modport master (
        output tick_1hz, alarm_en,
        output cur_h, cur_m, cur_s,
        output alm_h, alm_m, alm_s,
        output stop, snooze,
        input  ringing, snoozing, beep, snooze_cnt
    );

    modport slave (
        input  tick_1hz, alarm_en,
        input  cur_h, cur_m, cur_s,
        input  alm_h, alm_m, alm_s,
        input  stop, snooze,
        output ringing, snoozing, beep, snooze_cnt
    );

endinterface

// File: rtl/alarm_ctrl_beep_gen.sv
// rtl/alarm_ctrl_beep_gen.sv - tone square wave, half-period BEEP_DIV clocks, cleared when disabled
module beep_gen #(
    parameter int BEEP_DIV = 25000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tone
);

    localparam int               DIV_W    = $clog2(BEEP_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BEEP_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             tone_q, tone_d;

    always_comb begin
        div_d  = div_q;
        tone_d = tone_q;
        if (!en) begin
            div_d  = '0;
            tone_d = 1'b0;
        end else if (div_q == DIV_LAST) begin
            div_d  = '0;
            tone_d = ~tone_q;
        end else begin
            div_d  = div_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q  <= '0;
            tone_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            tone_q <= tone_d;
        end
    end

    assign tone = tone_q;

endmodule

// File: rtl/alarm_ctrl.sv
// rtl/alarm_ctrl.sv - alarm match edge detect, ring/snooze FSM with second counter, gated tone
module alarm_ctrl
    import alarm_ctrl_pkg::*;
#(
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_SEC = 300,
    parameter int MAX_SNOOZE = 3,
    parameter int BEEP_DIV   = 25000
) (
    input  logic         clk,
    input  logic         rst_n,
    alarm_ctrl_if.slave  bus
);

    localparam logic [SEC_CNT_W-1:0] RING_LAST   = SEC_CNT_W'(RING_SEC - 1);
    localparam logic [SEC_CNT_W-1:0] SNOOZE_LAST = SEC_CNT_W'(SNOOZE_SEC - 1);
    localparam logic [1:0]           SNZ_MAX     = 2'(MAX_SNOOZE);

    logic [1:0]           state_q, state_d;
    logic [SEC_CNT_W-1:0] sec_cnt_q, sec_cnt_d;
    logic [1:0]           snz_cnt_q, snz_cnt_d;
    logic                 match_dly_q, match_dly_d;
    logic                 ringing_q, ringing_d;
    logic                 snoozing_q, snoozing_d;

    hms_t cur_t, alm_t;
    logic match, trigger, tone;

    assign cur_t   = {bus.cur_h, bus.cur_m, bus.cur_s};
    assign alm_t   = {bus.alm_h, bus.alm_m, bus.alm_s};
    assign match   = hms_equal(cur_t, alm_t);
    assign trigger = match && !match_dly_q && bus.alarm_en;

    always_comb begin
        state_d     = state_q;
        sec_cnt_d   = sec_cnt_q;
        snz_cnt_d   = snz_cnt_q;
        match_dly_d = match;
        if (!bus.alarm_en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (trigger) begin
                        state_d   = ST_RING;
                        sec_cnt_d = '0;
                        snz_cnt_d = '0;
                    end
                end
                ST_RING: begin
                    if (bus.stop) begin
                        state_d = ST_IDLE;
                    end else if (bus.snooze) begin
                        // Once the snooze budget is spent a further press ends the event
                        if (snz_cnt_q < SNZ_MAX) begin
                            state_d   = ST_SNOOZE;
                            sec_cnt_d = '0;
                            snz_cnt_d = snz_cnt_q + 2'd1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else if (bus.tick_1hz) begin
                        if (sec_cnt_q == RING_LAST) begin
                            state_d = ST_IDLE;
                        end else begin
                            sec_cnt_d = sec_cnt_q + SEC_CNT_W'(1);
                        end
                    end
                end
                ST_SNOOZE: begin
                    if (bus.stop) begin
                        state_d = ST_IDLE;
                    end else if (bus.tick_1hz) begin
                        if (sec_cnt_q == SNOOZE_LAST) begin
                            state_d   = ST_RING;
                            sec_cnt_d = '0;
                        end else begin
                            sec_cnt_d = sec_cnt_q + SEC_CNT_W'(1);
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        if (state_d == ST_IDLE) begin
            sec_cnt_d = '0;
            snz_cnt_d = '0;
        end
        ringing_d  = (state_d == ST_RING);
        snoozing_d = (state_d == ST_SNOOZE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sec_cnt_q   <= '0;
            snz_cnt_q   <= '0;
            match_dly_q <= 1'b0;
            ringing_q   <= 1'b0;
            snoozing_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sec_cnt_q   <= sec_cnt_d;
            snz_cnt_q   <= snz_cnt_d;
            match_dly_q <= match_dly_d;
            ringing_q   <= ringing_d;
            snoozing_q  <= snoozing_d;
        end
    end

    // Enable follows the next state so the tone clears on the same edge ringing drops
    beep_gen #(
        .BEEP_DIV (BEEP_DIV)
    ) u_beep_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (ringing_d),
        .tone  (tone)
    );

    assign bus.ringing    = ringing_q;
    assign bus.snoozing   = snoozing_q;
    assign bus.beep       = tone;
    assign bus.snooze_cnt = snz_cnt_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// tb/tb_alarm_ctrl.sv - scoreboard bench for alarm_ctrl against a countdown reference model
module tb_alarm_ctrl;

    localparam int RING_SEC   = 5;
    localparam int SNOOZE_SEC = 3;
    localparam int MAX_SNOOZE = 3;
    localparam int BEEP_DIV   = 4;
    localparam int TPS        = 6;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alarm_ctrl_if bus();

    alarm_ctrl #(
        .RING_SEC   (RING_SEC),
        .SNOOZE_SEC (SNOOZE_SEC),
        .MAX_SNOOZE (MAX_SNOOZE),
        .BEEP_DIV   (BEEP_DIV)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic       ringing;
        logic       snoozing;
        logic       beep;
        logic [1:0] cnt;
    } obs_t;

    obs_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    bit m_ring, m_snz, m_prev_match;
    int m_left, m_used, m_ring_edges;

    int cur_sec, alm_sec;
    bit adv = 1'b1;
    bit en  = 1'b0;
    bit rst = 1'b0;

    function automatic int hms(input int h, input int m, input int s);
        return h * 3600 + m * 60 + s;
    endfunction

    task automatic model_step(input bit t, input bit st, input bit sn);
        bit   match, trig;
        obs_t o;
        match = (cur_sec == alm_sec);
        trig  = match && !m_prev_match && en;
        if (!rst) begin
            m_ring = 0; m_snz = 0; m_prev_match = 0; m_left = 0; m_used = 0;
        end else begin
            m_prev_match = match;
            if (!en) begin
                m_ring = 0; m_snz = 0;
            end else if (m_ring) begin
                if (st) begin
                    m_ring = 0;
                end else if (sn) begin
                    m_ring = 0;
                    if (m_used < MAX_SNOOZE) begin
                        m_snz = 1; m_used++; m_left = SNOOZE_SEC;
                    end
                end else if (t) begin
                    m_left--;
                    if (m_left == 0) m_ring = 0;
                end
            end else if (m_snz) begin
                if (st) begin
                    m_snz = 0;
                end else if (t) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_snz = 0; m_ring = 1; m_left = RING_SEC;
                    end
                end
            end else if (trig) begin
                m_ring = 1; m_left = RING_SEC; m_used = 0;
            end
            if (!m_ring && !m_snz) m_used = 0;
        end
        m_ring_edges = m_ring ? m_ring_edges + 1 : 0;
        o.ringing  = m_ring;
        o.snoozing = m_snz;
        o.beep     = ((m_ring_edges / BEEP_DIV) % 2) == 1;
        o.cnt      = 2'(m_used);
        exp_q.push_back(o);
    endtask

    task automatic cycle(input bit t, input bit st, input bit sn);
        if (t && adv) cur_sec = (cur_sec + 1) % 86400;
        rst_n        = rst;
        bus.tick_1hz = t;
        bus.stop     = st;
        bus.snooze   = sn;
        bus.alarm_en = en;
        bus.cur_h    = 5'(cur_sec / 3600);
        bus.cur_m    = 6'((cur_sec / 60) % 60);
        bus.cur_s    = 6'(cur_sec % 60);
        bus.alm_h    = 5'(alm_sec / 3600);
        bus.alm_m    = 6'((alm_sec / 60) % 60);
        bus.alm_s    = 6'(alm_sec % 60);
        model_step(t, st, sn);
        @(posedge clk);
        #1;
    endtask

    task automatic run_secs(input int n);
        for (int k = 0; k < n; k++) begin
            cycle(1'b1, 1'b0, 1'b0);
            for (int j = 1; j < TPS; j++) cycle(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic arm_in(input int secs);
        alm_sec = (cur_sec + secs) % 86400;
    endtask

    initial begin : monitor
        obs_t e, a;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {bus.ringing, bus.snoozing, bus.beep, bus.snooze_cnt};
                n_tests++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL outputs t=%0t: got ring=%0b snz=%0b beep=%0b cnt=%0d, expected ring=%0b snz=%0b beep=%0b cnt=%0d",
                             $time, a.ringing, a.snoozing, a.beep, a.cnt,
                             e.ringing, e.snoozing, e.beep, e.cnt);
                end
            end
        end
    end

    initial begin : stimulus
        cur_sec = hms(7, 29, 57);
        alm_sec = hms(7, 30, 0);
        rst = 1'b0;
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        rst = 1'b1;

        // ring on rising match, auto-stop after RING_SEC ticks, held match does not re-ring
        en = 1'b1;
        run_secs(3);
        adv = 1'b0;
        run_secs(10);
        adv = 1'b1;

        // snooze budget: three snoozes re-ring, the fourth ends the event
        arm_in(2);
        run_secs(3);
        for (int k = 0; k < MAX_SNOOZE; k++) begin
            cycle(0, 0, 1);
            run_secs(1);
            cycle(0, 0, 1);
            run_secs(SNOOZE_SEC + 1);
        end
        cycle(0, 0, 1);
        run_secs(2);

        // stop beats snooze; tick with stop
        arm_in(2);
        run_secs(3);
        cycle(0, 1, 1);
        run_secs(1);
        arm_in(2);
        run_secs(3);
        cycle(1, 1, 0);
        run_secs(1);

        // disable while snoozing, then a match with the alarm disarmed
        arm_in(2);
        run_secs(3);
        cycle(0, 0, 1);
        run_secs(1);
        en = 1'b0;
        cycle(0, 0, 0);
        arm_in(2);
        run_secs(4);
        en = 1'b1;
        run_secs(1);

        // reset mid-ring, then a fresh match rings normally
        arm_in(2);
        run_secs(3);
        rst = 1'b0;
        cycle(0, 0, 0);
        rst = 1'b1;
        arm_in(2);
        run_secs(8);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) en = ~en;
            if ($urandom_range(0, 99) == 0) arm_in(int'($urandom_range(1, 4)));
            rst = ($urandom_range(0, 999) != 0);
            cycle(i % TPS == 0, $urandom_range(0, 79) == 0, $urandom_range(0, 29) == 0);
        end
        rst = 1'b1;
        cycle(0, 0, 0);

        @(negedge clk);
        #1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected samples left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
